// File: rtl/ecc_apb_master_if.sv
// Command/response and APB signal bundle between a sequencer, the APB master and the ECC register bank.
interface ecc_apb_master_if #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20
) ();
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;
    logic                       rsp_valid;
    logic                       rsp_write;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       busy;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/ecc_apb_master.sv
// APB initiator: buffers register read/write commands and runs two-cycle SETUP/ACCESS transfers
// on a link without PREADY/PSLVERR, returning one response pulse per completed transfer.
module ecc_apb_master #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned CMD_DEPTH       = 2
) (
    input logic               clk,
    input logic               rst,
    ecc_apb_master_if.master  bus
);
    localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(CMD_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                       write;
        logic [AMBA_ADDR_WIDTH-1:0] addr;
        logic [AMBA_WORD-1:0]       wdata;
    } cmd_t;

    cmd_t                       r_mem [CMD_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_have_cmd;
    cmd_t                       w_head;
    logic [CNT_W-1:0]           w_count_next;

    logic                       r_cmd_ready;
    logic                       r_busy;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_rsp_valid;
    logic                       r_rsp_write;
    logic [AMBA_WORD-1:0]       r_rsp_rdata;

    assign w_push     = bus.cmd_valid && r_cmd_ready;
    // A command arriving into an empty buffer is forwarded straight to SETUP.
    assign w_have_cmd = (r_count != '0) || w_push;

    always_comb begin
        w_head = r_mem[r_rd_ptr];
        if (r_count == '0) begin
            w_head.write = bus.cmd_write;
            w_head.addr  = bus.cmd_addr;
            w_head.wdata = bus.cmd_wdata;
        end
    end

    // Next-state logic; the head entry is popped on every transition into SETUP.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_have_cmd) begin
                    w_state_next = S_SETUP;
                    w_pop        = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_have_cmd) begin
                    w_state_next = S_SETUP;
                    w_pop        = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Buffer storage carries no reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_pwrite <= w_head.write;
                r_paddr  <= w_head.addr;
                r_pwdata <= w_head.write ? w_head.wdata : '0;
            end
            r_count     <= w_count_next;
            r_cmd_ready <= (w_count_next != CNT_W'(CMD_DEPTH));
            r_busy      <= (w_count_next != '0) || (w_state_next != S_IDLE);
            r_psel      <= (w_state_next != S_IDLE);
            r_penable   <= (w_state_next == S_ACCESS);
            r_rsp_valid <= (r_state == S_ACCESS);
            if (r_state == S_ACCESS) begin
                r_rsp_write <= r_pwrite;
                r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
            end
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Bench for ecc_apb_master: APB slave model, in-order reference register file and a response scoreboard.
module tb_ecc_apb_master;
    typedef struct packed {
        logic        w;
        logic [19:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    ent_t exp_bus [$];
    ent_t exp_rsp [$];

    logic [31:0] slv      [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    logic [31:0] ref_regs [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0};

    ecc_apb_master_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) bus ();

    ecc_apb_master #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .CMD_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-bank slave: read data only presented during ACCESS.
    assign bus.PRDATA = (bus.PSEL && bus.PENABLE && !bus.PWRITE) ? slv[bus.PADDR[3:2]] : 32'h0;
    always @(posedge clk) begin
        if (bus.PSEL && bus.PENABLE && bus.PWRITE) slv[bus.PADDR[3:2]] <= bus.PWDATA;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [19:0] a, input logic [31:0] d);
        logic rdy;
        int   n;
        bit   done;
        ent_t e;
        done = 0;
        n    = 0;
        rdy  = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!done) begin
            rdy = bus.cmd_ready;
            @(negedge clk);
            n++;
            if (rdy) done = 1;
            else if (n > 50) begin
                chk("issue_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        bus.cmd_valid = 1'b0;
        if (rdy) begin
            e.w = w; e.a = a; e.d = w ? d : 32'h0;
            exp_bus.push_back(e);
            e.d = w ? 32'h0 : ref_regs[a[3:2]];
            exp_rsp.push_back(e);
            if (w) ref_regs[a[3:2]] = d;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || bus.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_rsp_left", 32'(exp_rsp.size()), 32'd0);
    endtask

    // Monitor: scoreboard for responses and per-transfer bus contents.
    initial begin : monitor
        logic prev_setup;
        ent_t prev_ent;
        ent_t e;
        prev_setup = 0;
        prev_ent   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rsp_valid) begin
                    if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_rsp.pop_front();
                        chk("rsp_write", 32'(bus.rsp_write), 32'(e.w));
                        chk("rsp_rdata", bus.rsp_rdata, e.d);
                    end
                end
                if (bus.PENABLE) begin
                    chk("access_psel", 32'(bus.PSEL), 32'd1);
                    chk("access_after_setup", 32'(prev_setup), 32'd1);
                    chk("setup_hold", 32'(prev_ent == {bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'd1);
                    if (exp_bus.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_bus.pop_front();
                        chk("pwrite", 32'(bus.PWRITE), 32'(e.w));
                        chk("paddr", 32'(bus.PADDR), 32'(e.a));
                        chk("pwdata", bus.PWDATA, e.d);
                    end
                end
                prev_setup = bus.PSEL && !bus.PENABLE;
                prev_ent   = {bus.PWRITE, bus.PADDR, bus.PWDATA};
            end else begin
                prev_setup = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rsp_t [$];
        int i0;
        int ready_lows;
        logic [19:0] a;
        logic        w;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            bus.cmd_valid = 1'($urandom);
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = 20'($urandom);
            bus.cmd_wdata = $urandom;
        end
        @(negedge clk);
        chk("rst_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.busy,
                            bus.PSEL, bus.PENABLE, bus.PWRITE}, 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_psel", 32'(bus.PSEL), 32'd0);

        // Single write, latency N+1 SETUP, N+2 ACCESS, N+3 response
        issue(1'b1, 20'h08, 32'h0000_001A);
        chk("wr_setup_ctl", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 32'b101);
        chk("wr_setup_paddr", 32'(bus.PADDR), 32'h08);
        chk("wr_setup_pwdata", bus.PWDATA, 32'h1A);
        @(negedge clk);
        chk("wr_access_ctl", {bus.PSEL, bus.PENABLE}, 32'b11);
        @(negedge clk);
        chk("wr_rsp", {bus.rsp_valid, bus.rsp_write}, 32'b11);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        chk("wr_idle", {bus.PSEL, bus.busy, bus.rsp_valid}, 32'b000);

        // Single read of preloaded 0xDEADBEEF
        issue(1'b0, 20'h04, 32'hFFFF_FFFF);
        chk("rd_setup_ctl", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 32'b100);
        chk("rd_setup_pwdata", bus.PWDATA, 32'h0);
        @(negedge clk);
        chk("rd_access_pwdata", bus.PWDATA, 32'h0);
        @(negedge clk);
        chk("rd_rsp", {bus.rsp_valid, bus.rsp_write}, 32'b10);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        drain();

        // Back-to-back writes filling the buffer
        fork
            begin
                issue(1'b1, 20'h00, $urandom);
                issue(1'b1, 20'h04, $urandom);
                issue(1'b1, 20'h08, $urandom);
                issue(1'b1, 20'h0C, $urandom);
            end
            begin
                i0 = -1;
                ready_lows = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (!bus.cmd_ready) ready_lows++;
                    if (i0 < 0 && bus.PSEL) i0 = i;
                    if (i0 >= 0 && i - i0 < 8) chk("b2b_psel", 32'(bus.PSEL), 32'd1);
                    if (bus.rsp_valid) rsp_t.push_back(i);
                end
                chk("b2b_full_seen", 32'(ready_lows != 0), 32'd1);
                chk("b2b_rsp_count", 32'(rsp_t.size()), 32'd4);
                if (rsp_t.size() == 4) begin
                    chk("b2b_first_rsp", 32'(rsp_t[0] - i0), 32'd2);
                    for (int k = 1; k < 4; k++)
                        chk("b2b_rsp_spacing", 32'(rsp_t[k] - rsp_t[k-1]), 32'd2);
                end
            end
        join
        drain();

        // Reset during ACCESS of a read with one more read queued
        issue(1'b0, 20'h00, 32'h0);
        issue(1'b0, 20'h08, 32'h0);
        chk("prerst_access", {bus.PSEL, bus.PENABLE}, 32'b11);
        #2;
        rst_n = 1'b0;
        exp_rsp.delete();
        exp_bus.delete();
        #1;
        chk("rst_async_drop", {bus.PSEL, bus.PENABLE}, 32'b00);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_empty", {bus.busy, bus.PSEL, bus.cmd_ready}, 32'b001);
        @(negedge clk);
        chk("rst_rel_no_rsp", {bus.rsp_valid, bus.PSEL}, 32'b00);

        // Same-cycle push and pop with one entry queued during ACCESS
        issue(1'b1, 20'h00, $urandom);
        issue(1'b1, 20'h04, $urandom);
        chk("pp_access", {bus.PSEL, bus.PENABLE}, 32'b11);
        issue(1'b0, 20'h00, 32'h0);
        chk("pp_occupancy_one", {bus.cmd_ready, bus.busy}, 32'b11);
        chk("pp_setup_next", {bus.PSEL, bus.PENABLE}, 32'b10);
        chk("pp_setup_addr", 32'(bus.PADDR), 32'h04);
        drain();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom);
            a = 20'({$urandom_range(0, 3), 2'b00});
            issue(w, a, $urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            a = 20'(k * 4);
            issue(1'b0, a, 32'h0);
        end
        drain();
        chk("final_bus_left", 32'(exp_bus.size()), 32'd0);
        chk("final_idle", {bus.busy, bus.PSEL}, 32'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ecc_apb_master.md
# ecc_apb_master

APB initiator that drives the register bank of the ECC encoder/decoder top from a simple command/response interface. It takes queued register read/write commands from a controller or testbench sequencer, runs the APB SETUP/ACCESS phases, and returns read data. It is the bus-master end of the same APB link the ECC top responds on. That link has no PREADY or PSLVERR, so every transfer is exactly two cycles.

## Interface
Parameters:
- AMBA_WORD, 32, PWDATA/PRDATA and command/response data width.
- AMBA_ADDR_WIDTH, 20, PADDR and command address width.
- CMD_DEPTH, 2, command buffer entries; a power of two, at least 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  buffer can accept a command; equals not-full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AMBA_ADDR_WIDTH  register address.
- cmd_wdata  in  AMBA_WORD  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse, one per completed transfer.
- rsp_write  out  1  echoes cmd_write of the completed transfer.
- rsp_rdata  out  AMBA_WORD  PRDATA captured for reads; 0 for writes.
- busy  out  1  buffer non-empty or FSM not IDLE.
- PSEL, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data.
- PRDATA  in  AMBA_WORD  APB read data from the ECC top.

## Operation
- Command buffer:
  - A FIFO of CMD_DEPTH entries {write, addr, wdata}.
  - Push on rising edge with cmd_valid && cmd_ready.
  - Pop when the FSM enters SETUP.
  - Push and pop in the same cycle are both honoured; occupancy is then unchanged.
  - Pointers wrap modulo CMD_DEPTH.
  - Occupancy counter is log2(CMD_DEPTH)+1 bits wide.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. Goes to SETUP when the buffer is non-empty.
  - SETUP: PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA loaded from the popped entry. Always goes to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; bus signals held. Goes to SETUP if the buffer is non-empty (next entry popped, PSEL stays 1), else to IDLE.
- Completion:
  - On the ACCESS→next edge, rsp_valid=1 for the following cycle and rsp_write = PWRITE.
  - rsp_rdata = PRDATA sampled on that edge for reads, 0 for writes.
- Bus values between transfers:
  - In IDLE, PADDR/PWRITE/PWDATA hold their last values.
  - For reads, PWDATA is driven 0.
- Decided ECC register offsets used by the bench: CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C.

## Timing
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and the buffer empties.
  - All outputs go to 0, except cmd_ready=1 once rst is released.
  - A transfer in flight is aborted: PSEL/PENABLE drop immediately and no rsp_valid is issued.
- Latency: command accepted at edge N (buffer was empty, FSM IDLE):
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2.
  - PRDATA sampled at the end of N+2.
  - rsp_valid in cycle N+3.
- Throughput: back-to-back commands give one transfer per 2 cycles, with PSEL continuously high and no IDLE gap.
- Full buffer: cmd_ready=0 and cmd_valid is ignored. cmd_ready rises the cycle after the pop edge.
- Push into an empty buffer while FSM is ACCESS: the next state is SETUP for that command, with no IDLE cycle.
- rsp_valid never stalls; there is no response back-pressure.

## Test plan
- Reset values: hold rst=0 for 3 cycles with random inputs.
  - Required: all outputs 0, busy=0.
  - After release, cmd_ready=1 and PSEL stays 0 with no command.
- Single write: write addr 0x08, data 0x0000001A.
  - Required: SETUP cycle with PSEL=1, PENABLE=0, PWRITE=1, PADDR=0x08, PWDATA=0x1A.
  - Then ACCESS with PENABLE=1.
  - rsp_valid=1 at N+3 with rsp_write=1, rsp_rdata=0; then IDLE.
- Single read: read 0x04 with the slave model returning 0xDEADBEEF in ACCESS.
  - Required: rsp_rdata=0xDEADBEEF and rsp_write=0 at N+3.
  - PWDATA=0 during the transfer.
- Back-to-back and full: push 4 writes (0x00, 0x04, 0x08, 0x0C) as fast as cmd_ready allows.
  - Required: cmd_ready=0 while 2 entries are held.
  - 4 transfers in 8 consecutive cycles with PSEL never dropping.
  - 4 rsp_valid pulses spaced 2 cycles apart, in address order.
- Reset mid-ACCESS: assert rst during the ACCESS of a read with 1 entry still queued.
  - Required: PSEL/PENABLE go to 0 asynchronously, no rsp_valid, buffer empty after release.
- Same-cycle push/pop: with 1 entry queued and FSM ACCESS, push a command on the pop edge.
  - Required: occupancy stays 1, both commands complete in order, and no command is lost or duplicated.
